// File: rtl/spi_adc_slave_20b_pkg.sv
// Shared constants for the 20-bit SPI ADC link. The master model and the
// slave both import this so the frame length, the convert-and-read command
// and the state encoding cannot drift apart.
package spi_adc_slave_20b_pkg;
  localparam int DATA_W = 20;
  localparam int CNT_W  = 5;
  localparam logic [DATA_W-1:0] CONVST_RD_CMD = 20'h80000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detect for one asynchronous SPI pin.
//   clk, rst_n : system clock, async active-low reset
//   d          : raw pin
//   q          : synchronized level (resets to RST_VAL)
//   rise, fall : single-cycle strobes on synchronized edges
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sr;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= sr[i-1];
      prev <= sr[SYNC_STAGES-1];
    end
  end

  assign q    = sr[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_adc_slave_20b.sv
// SPI slave emulating a dual-output 20-bit ADC: receives a command on MOSI
// and shifts two samples out on MISO A/B (CPOL=0, MSB first). All SPI pins
// are oversampled by clk (SCLK <= clk/8).
//   clk, sys_rst_n          : system clock, async active-low reset
//   tx_data_a/b, tx_load    : next samples, latched into holding regs on strobe
//   rx_cmd, rx_valid        : last good command and its update pulse
//   conv_req                : pulse with rx_valid when command == CONVST_RD_CMD
//   frame_err               : pulse when a frame ends with wrong bit count
//   tx_underrun             : pulse at frame start if no tx_load since last start
//   busy                    : frame in progress
//   spi_cs/clk/mosi         : SPI inputs; spi_miso_a/b : SPI outputs
module spi_adc_slave_20b #(
  parameter int DATA_W      = spi_adc_slave_20b_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] tx_data_a,
  input  logic [DATA_W-1:0] tx_data_b,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_cmd,
  output logic              rx_valid,
  output logic              conv_req,
  output logic              frame_err,
  output logic              tx_underrun,
  output logic              busy,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso_a,
  output logic              spi_miso_b
);
  import spi_adc_slave_20b_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  // Pin index: 0 = CS (idles high), 1 = SCLK, 2 = MOSI
  logic [2:0] pin, lvl, rise, fall;
  assign pin = {spi_mosi, spi_clk, spi_cs};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    spi_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_VAL    ((i == 0) ? 1'b1 : 1'b0)
    ) u_sync (
      .clk  (clk),
      .rst_n(sys_rst_n),
      .d    (pin[i]),
      .q    (lvl[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  logic unused_pins;
  assign unused_pins = ^{lvl[1], rise[2], fall[2]};

  wire cs_lvl    = lvl[0];
  wire cs_rise   = rise[0];
  wire cs_fall   = fall[0];
  wire sclk_rise = rise[1];
  wire sclk_fall = fall[1];
  wire mosi      = lvl[2];

  // The synchronizers reset to CS=1, so a CS held low through reset shows
  // up as a fake falling edge once the real level arrives. Frames are only
  // armed after CS has been seen high on settled synchronizer data.
  logic [SYNC_STAGES-1:0] settle;
  logic                   armed;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle <= '0;
    end else begin
      settle[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) settle[i] <= settle[i-1];
    end
  end

  state_t            state;
  logic [DATA_W-1:0] hold_a, hold_b, sr_a, sr_b, rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              loaded;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      hold_a      <= '0;
      hold_b      <= '0;
      sr_a        <= '0;
      sr_b        <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      loaded      <= 1'b0;
      armed       <= 1'b0;
      rx_cmd      <= '0;
      rx_valid    <= 1'b0;
      conv_req    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      spi_miso_a  <= 1'b0;
      spi_miso_b  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      conv_req    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      armed       <= armed | (settle[SYNC_STAGES-1] & cs_lvl);

      if (tx_load) begin
        hold_a <= tx_data_a;
        hold_b <= tx_data_b;
        loaded <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            // A load coinciding with the frame start goes straight out.
            sr_a        <= tx_load ? tx_data_a : hold_a;
            sr_b        <= tx_load ? tx_data_b : hold_b;
            spi_miso_a  <= tx_load ? tx_data_a[DATA_W-1] : hold_a[DATA_W-1];
            spi_miso_b  <= tx_load ? tx_data_b[DATA_W-1] : hold_b[DATA_W-1];
            tx_underrun <= ~(loaded | tx_load);
            loaded      <= 1'b0;   // this frame consumes any pending load
          end
        end
        SHIFT, WAIT_CS: begin
          if (cs_rise) begin
            state      <= IDLE;
            busy       <= 1'b0;
            spi_miso_a <= 1'b0;
            spi_miso_b <= 1'b0;
            if (bit_cnt == LAST) begin
              rx_cmd   <= rx_sr;
              rx_valid <= 1'b1;
              conv_req <= (rx_sr == DATA_W'(CONVST_RD_CMD));
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            // Keep counting in WAIT_CS so overlong frames are caught.
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == SHIFT) begin
              rx_sr <= {rx_sr[DATA_W-2:0], mosi};
              if (bit_cnt == LAST - CNT_W'(1)) begin
                state      <= WAIT_CS;
                spi_miso_a <= 1'b0;
                spi_miso_b <= 1'b0;
              end
            end
          end else if (sclk_fall && state == SHIFT) begin
            sr_a       <= {sr_a[DATA_W-2:0], 1'b0};
            sr_b       <= {sr_b[DATA_W-2:0], 1'b0};
            spi_miso_a <= sr_a[DATA_W-2];
            spi_miso_b <= sr_b[DATA_W-2];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_adc_slave_20b.sv
// Directed bench for spi_adc_slave_20b: a bit-banged SPI master (SCLK =
// clk/16) drives table-driven frames, then hand-written sequences cover a
// mid-frame tx_load and a reset in the middle of a CS-low frame.
module tb_spi_adc_slave_20b;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         sys_rst_n;
  logic [W-1:0] tx_data_a = '0, tx_data_b = '0;
  logic         tx_load = 1'b0;
  logic [W-1:0] rx_cmd;
  logic         rx_valid, conv_req, frame_err, tx_underrun, busy;
  logic         spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic         spi_miso_a, spi_miso_b;

  always #5 clk = ~clk;

  spi_adc_slave_20b #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .tx_data_a  (tx_data_a),
    .tx_data_b  (tx_data_b),
    .tx_load    (tx_load),
    .rx_cmd     (rx_cmd),
    .rx_valid   (rx_valid),
    .conv_req   (conv_req),
    .frame_err  (frame_err),
    .tx_underrun(tx_underrun),
    .busy       (busy),
    .spi_cs     (spi_cs),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso_a (spi_miso_a),
    .spi_miso_b (spi_miso_b)
  );

  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_conv = 0, n_orphan = 0, n_ferr = 0, n_under = 0;

  always @(posedge clk) begin
    if (rx_valid) n_valid++;
    if (conv_req && rx_valid) n_conv++;
    if (conv_req && !rx_valid) n_orphan++;
    if (frame_err) n_ferr++;
    if (tx_underrun) n_under++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_valid = 0; n_conv = 0; n_ferr = 0; n_under = 0;
  endtask

  task automatic qtr();
    repeat (4) @(negedge clk);
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    tx_data_a = a; tx_data_b = b; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One SCLK period: MOSI set early in the low phase, MISO sampled at rise.
  task automatic clk_bit(input logic m, output logic a, output logic b);
    spi_mosi = m;
    qtr();
    a = spi_miso_a; b = spi_miso_b;
    spi_clk = 1'b1;
    half();
    spi_clk = 1'b0;
    qtr();
  endtask

  task automatic frame(input logic [W-1:0] mosi, input int nbits, input int load_at,
                       input logic [W-1:0] la, input logic [W-1:0] lb,
                       output logic [W-1:0] ga, output logic [W-1:0] gb, output logic tail);
    logic a, b, m;
    ga = '0; gb = '0; tail = 1'b0;
    clr_cnt();
    spi_cs = 1'b0;
    half();
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == load_at) load(la, lb);
      m = (i < W) ? mosi[W-1-i] : 1'b0;
      clk_bit(m, a, b);
      if (i < W) begin
        ga = {ga[W-2:0], a};
        gb = {gb[W-2:0], b};
      end else if (a || b) begin
        tail = 1'b1;
      end
    end
    qtr();
    spi_cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    logic         ld;
    logic [W-1:0] a, b, mosi;
    int           nbits;
    logic [W-1:0] ea, eb, ecmd;
    int           ev, ec, ef, eu;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [W-1:0] ga, gb;
    logic         tail, bad, a, b;

    //           ld    A          B          MOSI       bits  exp A      exp B      exp cmd   v  c  fe un
    tv[0] = '{1'b1, 20'hA5A5A, 20'h0F0F0, 20'h80000, 20, 20'hA5A5A, 20'h0F0F0, 20'h80000, 1, 1, 0, 0};
    tv[1] = '{1'b1, 20'h33333, 20'hCCCCC, 20'h12345, 20, 20'h33333, 20'hCCCCC, 20'h12345, 1, 0, 0, 0};
    tv[2] = '{1'b1, 20'h54321, 20'hABCDE, 20'hFFFFF, 13, 20'h00A86, 20'h01579, 20'h12345, 0, 0, 1, 0};
    tv[3] = '{1'b1, 20'h0F00F, 20'hF00F0, 20'h80000, 24, 20'h0F00F, 20'hF00F0, 20'h12345, 0, 0, 1, 0};
    tv[4] = '{1'b0, 20'h00000, 20'h00000, 20'h00001, 20, 20'h0F00F, 20'hF00F0, 20'h00001, 1, 0, 0, 1};

    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst rx_cmd", 32'(rx_cmd), 32'd0);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst conv_req", 32'(conv_req), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst tx_underrun", 32'(tx_underrun), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst miso_a", 32'(spi_miso_a), 32'd0);
    chk("rst miso_b", 32'(spi_miso_b), 32'd0);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (tv[i].ld) load(tv[i].a, tv[i].b);
      frame(tv[i].mosi, tv[i].nbits, -1, '0, '0, ga, gb, tail);
      chk($sformatf("v%0d miso_a", i), 32'(ga), 32'(tv[i].ea));
      chk($sformatf("v%0d miso_b", i), 32'(gb), 32'(tv[i].eb));
      chk($sformatf("v%0d rx_cmd", i), 32'(rx_cmd), 32'(tv[i].ecmd));
      chk($sformatf("v%0d rx_valid", i), 32'(n_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d conv_req", i), 32'(n_conv), 32'(tv[i].ec));
      chk($sformatf("v%0d frame_err", i), 32'(n_ferr), 32'(tv[i].ef));
      chk($sformatf("v%0d tx_underrun", i), 32'(n_under), 32'(tv[i].eu));
      chk($sformatf("v%0d busy_after", i), 32'(busy), 32'd0);
      if (tv[i].nbits > W) chk($sformatf("v%0d miso_tail", i), 32'(tail), 32'd0);
    end

    // Load mid-frame: current frame keeps old data, next frame sends the new.
    load(20'h13579, 20'h2468A);
    frame(20'h00F0F, 20, 10, 20'hFFFFF, 20'hFFFFF, ga, gb, tail);
    chk("midload cur miso_a", 32'(ga), 32'h13579);
    chk("midload cur miso_b", 32'(gb), 32'h2468A);
    chk("midload cur underrun", 32'(n_under), 32'd0);
    chk("midload cur rx_cmd", 32'(rx_cmd), 32'h00F0F);
    frame(20'h80000, 20, -1, '0, '0, ga, gb, tail);
    chk("midload next miso_a", 32'(ga), 32'hFFFFF);
    chk("midload next miso_b", 32'(gb), 32'hFFFFF);
    chk("midload next underrun", 32'(n_under), 32'd0);
    chk("midload next conv_req", 32'(n_conv), 32'd1);

    // Reset at bit 8 with CS held low; the rest of that frame must be ignored.
    clr_cnt();
    spi_cs = 1'b0;
    half();
    for (int i = 0; i < 8; i++) clk_bit(1'b1, a, b);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clr_cnt();
    chk("midrst rx_cmd", 32'(rx_cmd), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst miso_a", 32'(spi_miso_a), 32'd0);
    chk("midrst miso_b", 32'(spi_miso_b), 32'd0);
    sys_rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clk_bit(1'b1, a, b);
      if (a || b || busy) bad = 1'b1;
    end
    qtr();
    spi_cs = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst quiet outputs", 32'(bad), 32'd0);
    chk("postrst rx_valid", 32'(n_valid), 32'd0);
    chk("postrst frame_err", 32'(n_ferr), 32'd0);
    chk("postrst underrun", 32'(n_under), 32'd0);
    chk("postrst rx_cmd", 32'(rx_cmd), 32'd0);

    load(20'h3C3C3, 20'hC3C3C);
    frame(20'h80000, 20, -1, '0, '0, ga, gb, tail);
    chk("recover miso_a", 32'(ga), 32'h3C3C3);
    chk("recover miso_b", 32'(gb), 32'hC3C3C);
    chk("recover rx_cmd", 32'(rx_cmd), 32'h80000);
    chk("recover rx_valid", 32'(n_valid), 32'd1);
    chk("recover conv_req", 32'(n_conv), 32'd1);
    chk("recover underrun", 32'(n_under), 32'd0);

    chk("conv_req without rx_valid", 32'(n_orphan), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_adc_slave_20b.md
SPI_ADC_SLAVE_20B -- requirements
Module: spi_adc_slave_20b

Interface
REQ-001 SHALL have parameter DATA_W, default 20, frame length in bits and width of every data/command port.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each SPI input.
REQ-003 SHALL have port clk, input, 1, the single system clock; SCLK SHALL be at most clk/8.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tx_data_a, input, DATA_W, the next sample for SDOA.
REQ-006 SHALL have port tx_data_b, input, DATA_W, the next sample for SDOB.
REQ-007 SHALL have port tx_load, input, 1, a one-cycle strobe that latches tx_data_a/b into holding registers.
REQ-008 SHALL have port rx_cmd, output, DATA_W, the last complete command received.
REQ-009 SHALL have port rx_valid, output, 1, a one-cycle pulse when rx_cmd updates.
REQ-010 SHALL have port conv_req, output, 1, a one-cycle pulse when a received command equals CONVST_RD_CMD.
REQ-011 SHALL have port frame_err, output, 1, a one-cycle pulse when a frame ends with a bit count other than DATA_W.
REQ-012 SHALL have port tx_underrun, output, 1, a one-cycle pulse when a frame starts without tx_load since the previous frame start.
REQ-013 SHALL have port busy, output, 1, high while the state is not IDLE.
REQ-014 SHALL have port spi_cs, input, 1, active-low chip select.
REQ-015 SHALL have port spi_clk, input, 1, SCLK with CPOL=0.
REQ-016 SHALL have port spi_mosi, input, 1, command in, MSB first.
REQ-017 SHALL have ports spi_miso_a and spi_miso_b, output, 1 each, data out, MSB first.

Function
REQ-018 spi_cs, spi_clk and spi_mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized values.
REQ-019 The state machine SHALL have three states: IDLE, SHIFT and WAIT_CS.
- IDLE to SHIFT on a CS falling edge.
- SHIFT to WAIT_CS after the DATA_W-th SCLK rising edge.
- SHIFT or WAIT_CS to IDLE on a CS rising edge.
REQ-020 On entry to SHIFT, the holding registers SHALL be copied into the tx shift registers, and each MSB SHALL drive MISO on the next clk cycle.
REQ-021 MOSI SHALL be sampled on each synchronized SCLK rising edge.
REQ-022 The tx shift registers SHALL advance one bit on each SCLK falling edge in SHIFT.
REQ-023 The bit counter SHALL be 5 bits wide and SHALL saturate at 31.
REQ-024 The bit counter SHALL count rising edges from CS low to CS high, including edges that arrive in WAIT_CS.
REQ-025 MISO SHALL be 0 whenever the state is not SHIFT, and after the DATA_W-th falling edge.
REQ-026 On a CS rising edge with bit count equal to DATA_W, the block SHALL update rx_cmd and pulse rx_valid one cycle later.
REQ-027 conv_req SHALL pulse in the same cycle as rx_valid when the command equals CONVST_RD_CMD.
REQ-028 On a CS rising edge with bit count not equal to DATA_W, the block SHALL pulse frame_err, SHALL leave rx_cmd unchanged, and SHALL NOT pulse rx_valid.
REQ-029 A tx_load during a frame SHALL update only the holding registers; the change SHALL take effect at the next frame.
REQ-030 A tx_load in the same cycle as a frame start SHALL be copied into the shift registers.
REQ-031 tx_underrun SHALL pulse at a frame start when no tx_load occurred since the previous frame start; the old holding data SHALL be resent.
REQ-032 SCLK edges SHALL be ignored while in IDLE.
REQ-033 If CS is low when reset is released, the block SHALL remain in IDLE until CS goes high and then falls again.

Reset
REQ-034 Asserting sys_rst_n low SHALL clear the following:
- state to IDLE;
- all synchronizers to CS=1, SCLK=0, MOSI=0;
- shift, holding and counter registers;
- rx_cmd to 0;
- all pulse outputs, busy and both MISO outputs to 0.
REQ-035 A reset during a frame SHALL abort that frame without any rx_valid or frame_err pulse.

Structure
REQ-036 A shared package SHALL hold DATA_W, CONVST_RD_CMD (20'h80000) and the state encoding, so that the master and the slave use the same values.
REQ-037 The input synchronizer plus edge detector SHALL be one sub-module, spi_sync_edge, instantiated once per SPI input.

Verification
REQ-038 Scenario: tx_load with A=20'hA5A5A, B=20'h0F0F0; run a 20-bit frame with MOSI=20'h80000. Required: MISO A/B shift out A5A5A/0F0F0 MSB first; rx_cmd=80000; rx_valid and conv_req pulse once.
REQ-039 Scenario: a frame with MOSI=20'h12345. Required: rx_valid pulses, rx_cmd=12345, and conv_req does not pulse.
REQ-040 Scenario: CS high after 13 SCLKs, and separately after 24 SCLKs. Required: frame_err pulses each time; rx_cmd keeps its previous value; MISO=0 after bit 20.
REQ-041 Scenario: two frames with no tx_load between them. Required: tx_underrun pulses at the second frame start, and the previous data repeats on MISO.
REQ-042 Scenario: tx_load of 20'hFFFFF at bit 10 of a frame. Required: the current frame completes with the old data; the next frame sends FFFFF.
REQ-043 Scenario: sys_rst_n pulled low at bit 8 while CS stays low, then released. Required: all outputs are 0 and there is no pulse; the next full CS-low frame is received correctly.
